// File: rtl/instr_fetch_stage_if.sv
// Fetch-stage bundle: control inputs, imem address/data and the IF/ID register outputs.
// master = fetch stage side, slave = environment (hazard unit, branch unit, imem, decoder).
interface instr_fetch_stage_if #(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 32
);
  logic                 start;
  logic                 halt_req;
  logic                 stall;
  logic                 branch_taken;
  logic [PC_WIDTH-1:0]  branch_target;
  logic [PC_WIDTH-1:0]  imem_addr;
  logic [31:0]          imem_data;
  logic [31:0]          instr_out;
  logic [PC_WIDTH-1:0]  pc_out;
  logic                 instr_valid;
  logic [1:0]           state_out;
  logic [CNT_WIDTH-1:0] fetch_count;

  modport master (
    input  start, halt_req, stall, branch_taken, branch_target, imem_data,
    output imem_addr, instr_out, pc_out, instr_valid, state_out, fetch_count
  );

  modport slave (
    output start, halt_req, stall, branch_taken, branch_target, imem_data,
    input  imem_addr, instr_out, pc_out, instr_valid, state_out, fetch_count
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// IF stage + IF/ID register; a word fetched at PC P appears on instr_out/pc_out one cycle later.
// stall freezes PC and IF/ID; a branch redirect overrides stall and flushes with a NOP bubble.
module instr_fetch_stage #(
  parameter int          PC_WIDTH  = 32,
  parameter int          PC_INC    = 1,
  parameter logic [31:0] NOP_INSTR = 32'hF000_0000,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_t;

  state_t               state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [31:0]          instr_q, instr_d;
  logic [PC_WIDTH-1:0]  pc_out_q, pc_out_d;
  logic                 valid_q, valid_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      instr_q  <= NOP_INSTR;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
        if (bus.start) state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.halt_req) begin
          state_d = S_HALT;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end else if (bus.branch_taken) begin
          // The word currently at imem_addr is wrong-path; replace it with a bubble.
          pc_d     = bus.branch_target;
          instr_d  = NOP_INSTR;
          valid_d  = 1'b0;
          pc_out_d = pc_q;
        end else if (!bus.stall) begin
          instr_d  = bus.imem_data;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          pc_d     = pc_q + PC_WIDTH'(PC_INC);
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
      end
      S_HALT: begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.imem_addr   = pc_q;
  assign bus.instr_out   = instr_q;
  assign bus.pc_out      = pc_out_q;
  assign bus.instr_valid = valid_q;
  assign bus.state_out   = state_q;
  assign bus.fetch_count = cnt_q;

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
- IF stage plus IF/ID pipeline register. Sits directly upstream of the instruction decoder.
- Holds the PC and drives the instruction-memory address (combinational-read imem, data returned in the same cycle).
- Registers the fetched word and its PC into the IF/ID register.
- Handles hazard-unit stalls, branch redirect/flush (VBNZ/VBENZ resolved downstream), start/halt, and a fetch counter.

Parameters:
- PC_WIDTH, 32, width of PC, imem address and branch target.
- PC_INC, 1, PC increment per fetch (word-addressed imem).
- NOP_INSTR, 32'hF000_0000, bubble instruction (opcode 6'b111100) injected on reset, idle, flush and halt.
- CNT_WIDTH, 32, width of fetch counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  leave IDLE and begin fetching.
- halt_req  in  1  stop fetching permanently until reset.
- stall  in  1  hazard-unit stall; freeze PC and IF/ID.
- branch_taken  in  1  redirect request from branch resolution.
- branch_target  in  PC_WIDTH  redirect PC.
- imem_addr  out  PC_WIDTH  instruction-memory address (= PC register).
- imem_data  in  32  instruction word at imem_addr, same cycle.
- instr_out  out  32  IF/ID instruction, feeds decoder.
- pc_out  out  PC_WIDTH  PC of instr_out.
- instr_valid  out  1  instr_out is a real fetched instruction (not a bubble).
- state_out  out  2  FSM state: 00 IDLE, 01 RUN, 10 HALT.
- fetch_count  out  CNT_WIDTH  number of accepted fetches.

Behaviour:
- Reset (reset==0 at posedge, any state, mid-stall or mid-branch included):
  - pc=0, instr_out=NOP_INSTR, pc_out=0, instr_valid=0, fetch_count=0, state=IDLE.
  - Reset overrides all other inputs.
- imem_addr is continuously assigned from the pc register.
- IDLE:
  - pc held; IF/ID holds NOP/valid 0.
  - start==1 → RUN next cycle. The first fetch happens in the first RUN cycle. No fetch occurs in the cycle start is sampled.
  - stall and branch_taken are ignored in IDLE.
- RUN, one action per cycle, priority halt_req > branch_taken > stall > fetch:
  - halt_req: state→HALT; instr_out=NOP, instr_valid=0; pc unchanged; a pending branch is discarded.
  - branch_taken: pc←branch_target; instr_out←NOP, instr_valid←0, pc_out←pc (flush the wrong-path word); fetch_count unchanged. Branch overrides a simultaneous stall.
  - stall: pc, instr_out, pc_out, instr_valid and fetch_count all hold. imem_data is ignored.
  - fetch: instr_out←imem_data, pc_out←pc, instr_valid←1, pc←pc+PC_INC modulo 2^PC_WIDTH, fetch_count+1.
- Latency: a word presented at imem_addr=P in a fetch cycle appears on instr_out/pc_out=P the next cycle.
- Wrap-around: PC 2^PC_WIDTH−1 + 1 → 0, no flag. fetch_count saturates at all-ones and does not wrap.
- HALT: absorbing state until reset.
  - IF/ID holds NOP/valid 0; pc frozen.
  - start, stall and branch are ignored.
- A start pulse while in RUN or HALT has no effect.
- Multi-cycle stall: holds indefinitely; the fetch resumes at the same pc with no skipped or duplicated instructions.

Test Plan:
- Reset then start at cycle 2, imem returns 0xA8000000|addr → instr_out sequence starts 0xA8000000 at pc_out 0, then 1, 2; instr_valid=1; fetch_count 3 after 3 fetches.
- Stall held 3 cycles at pc=5 → pc_out/instr_out frozen (pc_out=4), imem_addr=5 throughout; after release pc_out=5, with no duplicate or skip.
- branch_taken with target 0x40 while pc=7 → next cycle instr_out=0xF0000000, valid 0, imem_addr=0x40; following cycle pc_out=0x40.
- branch_taken and stall asserted together → branch wins (imem_addr=target, bubble). halt_req and branch together → HALT, pc unchanged.
- pc preloaded via branch to 0xFFFFFFFF, one fetch → imem_addr=0, pc_out=0xFFFFFFFF.
- Reset asserted during stall in RUN → next cycle state=IDLE, pc=0, instr_out=0xF0000000, fetch_count=0; stall and branch ignored until start.
